// File: rtl/tank_scan_controller.sv
// Sensor mux scan sequencer for the tank monitor.
// Walks the four sensor channels and samples each one after a settle window.
// Each sample is checked against fixed thresholds. The channel alarms are
// committed once per scan, and repeated alarmed scans put the mux into error
// mode.
module tank_scan_controller #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  CLEAN_MIN     = 8'd32,
  parameter logic [7:0]  TEMP_MIN      = 8'd20,
  parameter logic [7:0]  TEMP_MAX      = 8'd30,
  parameter logic [7:0]  FOOD_MIN      = 8'd16,
  parameter logic [7:0]  SALT_MAX      = 8'd64,
  parameter int unsigned ERR_LIMIT     = 3
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic       clear_error,
  input  logic [7:0] mux_out,
  output logic [4:0] select,
  output logic       busy,
  output logic       done,
  output logic       sample_valid,
  output logic [1:0] sample_idx,
  output logic [7:0] sample_data,
  output logic [3:0] alarm,
  output logic       error_mode
);

  localparam int unsigned WIN      = SETTLE_CYCLES + 1;
  localparam logic [3:0]  WIN_LAST = 4'(WIN - 1);
  localparam logic [2:0]  ERR_LIM  = 3'(ERR_LIMIT);
  localparam logic [4:0]  SEL_IDLE = 5'b00000;
  localparam logic [4:0]  SEL_ERR  = 5'b11111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t     r_state;
  logic [1:0] r_idx;
  logic [3:0] r_win;
  logic [3:0] r_shadow;
  logic [2:0] r_fault;
  logic [4:0] r_select;
  logic       r_busy;
  logic       r_done;
  logic       r_valid;
  logic [1:0] r_sidx;
  logic [7:0] r_sdata;
  logic [3:0] r_alarm;
  logic       r_err;

  logic       w_fail;
  logic       w_win_last;
  logic [3:0] w_shadow_next;
  logic [2:0] w_fault_next;

  // One-hot select code for a channel: bit (idx+1).
  function automatic logic [4:0] chan_code(input logic [1:0] idx);
    return 5'(5'b00010 << idx);
  endfunction

  // Threshold check for the channel currently on the mux; boundaries pass.
  always_comb begin
    w_fail = 1'b0;
    case (r_idx)
      2'd0:    w_fail = (mux_out < CLEAN_MIN);
      2'd1:    w_fail = (mux_out < TEMP_MIN) || (mux_out > TEMP_MAX);
      2'd2:    w_fail = (mux_out < FOOD_MIN);
      default: w_fail = (mux_out > SALT_MAX);
    endcase
  end

  assign w_win_last    = (r_win == WIN_LAST);
  assign w_shadow_next = r_shadow | 4'(4'(w_fail) << r_idx);
  // Fault counter: saturates at 7 on an alarmed scan, clears on a clean one.
  assign w_fault_next  = (w_shadow_next != 4'd0) ?
                         ((r_fault == 3'd7) ? 3'd7 : r_fault + 3'd1) : 3'd0;

  // Scan state machine with registered outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= 2'd0;
      r_win    <= 4'd0;
      r_shadow <= 4'd0;
      r_fault  <= 3'd0;
      r_select <= SEL_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_sidx   <= 2'd0;
      r_sdata  <= 8'd0;
      r_alarm  <= 4'd0;
      r_err    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_SCAN;
            r_idx    <= 2'd0;
            r_win    <= 4'd0;
            r_select <= chan_code(2'd0);
            r_busy   <= 1'b1;
          end
        end
        S_SCAN: begin
          if (w_win_last) begin
            r_valid <= 1'b1;
            r_sidx  <= r_idx;
            r_sdata <= mux_out;
            if (r_idx == 2'd3) begin
              r_state  <= S_DONE;
              r_select <= SEL_IDLE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_alarm  <= w_shadow_next;
              r_shadow <= 4'd0;
              r_fault  <= w_fault_next;
            end else begin
              r_shadow <= w_shadow_next;
              r_idx    <= r_idx + 2'd1;
              r_win    <= 4'd0;
              r_select <= chan_code(r_idx + 2'd1);
            end
          end else begin
            r_win <= r_win + 4'd1;
          end
        end
        S_DONE: begin
          if (r_fault >= ERR_LIM) begin
            r_state  <= S_ERROR;
            r_select <= SEL_ERR;
            r_err    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ERROR: begin
          if (clear_error) begin
            r_state  <= S_IDLE;
            r_select <= SEL_IDLE;
            r_err    <= 1'b0;
            r_alarm  <= 4'd0;
            r_fault  <= 3'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign select       = r_select;
  assign busy         = r_busy;
  assign done         = r_done;
  assign sample_valid = r_valid;
  assign sample_idx   = r_sidx;
  assign sample_data  = r_sdata;
  assign alarm        = r_alarm;
  assign error_mode   = r_err;

endmodule

// File: tb/tb_tank_scan_controller.sv
// Bench for tank_scan_controller: default-window instance plus a W=1 instance,
// each fed by a small sensor mux model, checked against a scan-level model.
module tb_tank_scan_controller;

  localparam int WA = 3;
  localparam int WB = 1;
  localparam int ERR_LIM = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, clr_a, start_b, clr_b;
  logic [7:0] mux_a, mux_b;
  logic [4:0] sel_a, sel_b;
  logic       busy_a, done_a, sv_a, err_a;
  logic       busy_b, done_b, sv_b, err_b;
  logic [1:0] sidx_a, sidx_b;
  logic [7:0] sdata_a, sdata_b;
  logic [3:0] alarm_a, alarm_b;

  logic [7:0] sens_a [4];
  logic [7:0] sens_b [4];

  int n_assert = 0;
  int n_fail   = 0;
  int fcnt     = 0;
  logic [3:0] last_alarm = 4'd0;

  always #5 clk = ~clk;

  tank_scan_controller u_dut_a (
    .CLK(clk), .reset(reset), .start(start_a), .clear_error(clr_a),
    .mux_out(mux_a), .select(sel_a), .busy(busy_a), .done(done_a),
    .sample_valid(sv_a), .sample_idx(sidx_a), .sample_data(sdata_a),
    .alarm(alarm_a), .error_mode(err_a)
  );

  tank_scan_controller #(.SETTLE_CYCLES(0)) u_dut_b (
    .CLK(clk), .reset(reset), .start(start_b), .clear_error(clr_b),
    .mux_out(mux_b), .select(sel_b), .busy(busy_b), .done(done_b),
    .sample_valid(sv_b), .sample_idx(sidx_b), .sample_data(sdata_b),
    .alarm(alarm_b), .error_mode(err_b)
  );

  // Sensor mux models: route the selected sensor register to the output.
  always_comb begin
    case (sel_a)
      5'b00010: mux_a = sens_a[0];
      5'b00100: mux_a = sens_a[1];
      5'b01000: mux_a = sens_a[2];
      5'b10000: mux_a = sens_a[3];
      default:  mux_a = 8'hA5;
    endcase
  end

  always_comb begin
    case (sel_b)
      5'b00010: mux_b = sens_b[0];
      5'b00100: mux_b = sens_b[1];
      5'b01000: mux_b = sens_b[2];
      5'b10000: mux_b = sens_b[3];
      default:  mux_b = 8'h5A;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_sel"},   32'(sel_a),   32'd0);
    chk({tag, "_busy"},  32'(busy_a),  32'd0);
    chk({tag, "_done"},  32'(done_a),  32'd0);
    chk({tag, "_sv"},    32'(sv_a),    32'd0);
    chk({tag, "_idx"},   32'(sidx_a),  32'd0);
    chk({tag, "_data"},  32'(sdata_a), 32'd0);
    chk({tag, "_alarm"}, 32'(alarm_a), 32'd0);
    chk({tag, "_err"},   32'(err_a),   32'd0);
  endtask

  // In ERROR: start is ignored, clear_error returns to a clean IDLE.
  task automatic err_recover_a();
    start_a = 1'b1;
    repeat (2) begin
      tick();
      chk("a_errsel",   32'(sel_a),   32'd31);
      chk("a_errmode",  32'(err_a),   32'd1);
      chk("a_errbusy",  32'(busy_a),  32'd0);
      chk("a_erralarm", 32'(alarm_a), 32'(last_alarm));
    end
    start_a = 1'b0;
    clr_a   = 1'b1;
    tick();
    clr_a = 1'b0;
    chk("a_clrsel",   32'(sel_a),   32'd0);
    chk("a_clrerr",   32'(err_a),   32'd0);
    chk("a_clralarm", 32'(alarm_a), 32'd0);
    chk("a_clrbusy",  32'(busy_a),  32'd0);
    fcnt       = 0;
    last_alarm = 4'd0;
    tick();
    chk("a_idlesel", 32'(sel_a), 32'd0);
  endtask

  // One full scan on instance A, checked cycle by cycle against the model.
  task automatic scan_a(input logic [7:0] c, input logic [7:0] t,
                        input logic [7:0] f, input logic [7:0] s);
    logic [3:0]  ea;
    logic [31:0] es;
    bit          err_exp;
    bit          v;
    sens_a = '{c, t, f, s};
    ea[0] = (c < 8'd32);
    ea[1] = (t < 8'd20) || (t > 8'd30);
    ea[2] = (f < 8'd16);
    ea[3] = (s > 8'd64);
    if (ea != 4'd0) fcnt = (fcnt == 7) ? 7 : fcnt + 1;
    else            fcnt = 0;
    err_exp = (fcnt >= ERR_LIM);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int j = 0; j <= 4*WA + 1; j++) begin
      if (j > 0) tick();
      if (j < 4*WA)       es = 32'd2 << (j / WA);
      else if (j == 4*WA) es = 32'd0;
      else                es = err_exp ? 32'd31 : 32'd0;
      chk("a_select", 32'(sel_a), es);
      chk("a_busy", 32'(busy_a), 32'(j < 4*WA));
      v = (j > 0) && (j % WA == 0) && (j <= 4*WA);
      chk("a_valid", 32'(sv_a), 32'(v));
      if (v) begin
        chk("a_idx",  32'(sidx_a),  32'(j / WA - 1));
        chk("a_data", 32'(sdata_a), 32'(sens_a[j / WA - 1]));
      end
      chk("a_done", 32'(done_a), 32'(j == 4*WA));
      chk("a_alarm", 32'(alarm_a), 32'((j >= 4*WA) ? ea : last_alarm));
      chk("a_errmode", 32'(err_a), 32'((j == 4*WA + 1) && err_exp));
    end
    last_alarm = ea;
    if (err_exp) err_recover_a();
  endtask

  initial begin
    logic [31:0] es;
    int          p;
    int          sc;
    reset   = 1'b1;
    start_a = 1'b0; clr_a = 1'b0;
    start_b = 1'b0; clr_b = 1'b0;
    sens_a  = '{8'd40, 8'd25, 8'd20, 8'd50};
    sens_b  = '{8'd40, 8'd25, 8'd20, 8'd50};
    repeat (2) @(negedge clk);
    chk_zero_a("rst");
    chk("rst_b_sel", 32'(sel_b), 32'd0);
    reset = 1'b0;
    tick();

    // Nominal values, then inclusive boundaries and single-side violations.
    scan_a(8'd40, 8'd25, 8'd20, 8'd50);
    scan_a(8'd32, 8'd30, 8'd16, 8'd64);
    scan_a(8'd32, 8'd31, 8'd16, 8'd64);
    scan_a(8'd31, 8'd19, 8'd16, 8'd64);
    scan_a(8'd40, 8'd25, 8'd20, 8'd50);
    // Three salty scans in a row reach the error limit.
    repeat (3) scan_a(8'd40, 8'd25, 8'd20, 8'd65);
    // A clean scan between faults restarts the count.
    scan_a(8'd40, 8'd25, 8'd20, 8'd65);
    scan_a(8'd40, 8'd25, 8'd20, 8'd65);
    scan_a(8'd40, 8'd25, 8'd20, 8'd50);
    scan_a(8'd40, 8'd25, 8'd20, 8'd65);
    scan_a(8'd40, 8'd25, 8'd20, 8'd65);

    // Random values straddling every threshold.
    repeat (24) begin
      scan_a(8'($urandom_range(26, 38)), 8'($urandom_range(16, 34)),
             8'($urandom_range(12, 20)), 8'($urandom_range(60, 68)));
    end

    // Reset in the channel-1 window clears everything without a clock edge.
    scan_a(8'd40, 8'd25, 8'd20, 8'd50);
    scan_a(8'd40, 8'd25, 8'd20, 8'd65);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero_a("midrst");
    @(negedge clk);
    reset      = 1'b0;
    fcnt       = 0;
    last_alarm = 4'd0;
    tick();
    chk("postrst_done", 32'(done_a), 32'd0);
    chk("postrst_sv",   32'(sv_a),   32'd0);
    scan_a(8'd40, 8'd25, 8'd20, 8'd50);

    // W=1 with start held: 6-cycle scans, four back-to-back samples each;
    // salt goes bad from the fourth scan, so the sixth ends in ERROR.
    start_b = 1'b1;
    tick();
    for (int j = 0; j < 36; j++) begin
      if (j > 0) tick();
      p  = j % (4*WB + 2);
      sc = j / (4*WB + 2);
      if (p < 4)       es = 32'd2 << p;
      else if (p == 4) es = 32'd0;
      else             es = (sc == 5) ? 32'd31 : 32'd0;
      chk("b_select", 32'(sel_b), es);
      chk("b_valid", 32'(sv_b), 32'(p >= 1 && p <= 4));
      if (p >= 1 && p <= 4) begin
        chk("b_idx",  32'(sidx_b),  32'(p - 1));
        chk("b_data", 32'(sdata_b), 32'(sens_b[p - 1]));
      end
      chk("b_done", 32'(done_b), 32'(p == 4));
      if (p == 4) chk("b_alarm", 32'(alarm_b), (sc >= 3) ? 32'd8 : 32'd0);
      chk("b_errmode", 32'(err_b), 32'(j == 35));
      if (j == 17) sens_b[3] = 8'd65;
    end
    // clear_error wins over a simultaneous start.
    clr_b = 1'b1;
    tick();
    chk("b_clrsel",   32'(sel_b),   32'd0);
    chk("b_clrerr",   32'(err_b),   32'd0);
    chk("b_clrbusy",  32'(busy_b),  32'd0);
    chk("b_clralarm", 32'(alarm_b), 32'd0);
    chk("b_clrsv",    32'(sv_b),    32'd0);
    clr_b   = 1'b0;
    start_b = 1'b0;
    tick();
    chk("b_idlesel",  32'(sel_b),  32'd0);
    chk("b_idlebusy", 32'(busy_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tank_scan_controller.md
# tank_scan_controller

Sequencer that drives the 5-bit select input of the tank sensor mux. It walks the four sensor channels (cleanliness, temperature, food storage, saltiness) and samples the 8-bit mux output after a settle window. Each sample is checked against fixed thresholds, and persistent faults drive the mux into error mode (select 11111). It sits between the tank sensor registers/mux and the status/alarm logic.

## Interface
Parameters:
- SETTLE_CYCLES, 2, extra cycles select is held before sampling; legal 0..15; channel window W = SETTLE_CYCLES+1
- CLEAN_MIN, 8'd32, minimum acceptable cleanliness
- TEMP_MIN, 8'd20, minimum acceptable temperature
- TEMP_MAX, 8'd30, maximum acceptable temperature
- FOOD_MIN, 8'd16, minimum acceptable food storage
- SALT_MAX, 8'd64, maximum acceptable saltiness
- ERR_LIMIT, 3, consecutive alarmed scans that trigger error mode; legal 1..7

Ports:
- CLK  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin a scan; sampled only in IDLE
- clear_error  in  1  leave ERROR; sampled only in ERROR
- mux_out  in  8  data output of sensor mux
- select  out  5  mux select code, registered
- busy  out  1  high while scanning (SCAN state)
- done  out  1  one-cycle pulse at scan completion
- sample_valid  out  1  one-cycle pulse per captured channel
- sample_idx  out  2  channel of current sample (0 clean, 1 temp, 2 food, 3 salt)
- sample_data  out  8  captured mux_out
- alarm  out  4  per-channel alarm, bit i = channel i, committed at scan end
- error_mode  out  1  high in ERROR

## Operation
- States: IDLE, SCAN, DONE, ERROR.
- Select codes: IDLE/DONE 00000; channels 0..3 = 00010, 00100, 01000, 10000; ERROR 11111. No other codes are ever driven.
- IDLE: start=1 -> SCAN, channel index 0, window counter 0. start is ignored in SCAN, DONE and ERROR.
- SCAN: select holds the current channel code for W cycles. At the last edge of the window, mux_out is captured into sample_data/sample_idx and sample_valid is pulsed. The threshold result is ORed into the shadow alarm bit, then the index advances. After channel 3 is captured -> DONE.
- Threshold checks are unsigned and boundaries are inclusive-OK:
  - clean alarms if < CLEAN_MIN
  - temp alarms if < TEMP_MIN or > TEMP_MAX
  - food alarms if < FOOD_MIN
  - salt alarms if > SALT_MAX
- Entering DONE:
  - alarm <= shadow; shadow cleared; done=1.
  - If shadow is nonzero, the 3-bit fault counter increments, saturating at 7; otherwise it clears.
  - If the counter reaches ERR_LIMIT, the next state is ERROR; otherwise IDLE. DONE lasts exactly one cycle.
- ERROR: error_mode=1, select=11111, alarm holds. clear_error=1 -> IDLE with alarm, fault counter and error_mode cleared. If start and clear_error are both high, clear wins and start is dropped.
- Reset (any time, including mid-scan): state IDLE; all outputs, counters and shadow are 0 immediately; select=00000.

## Timing
- start sampled at edge k; select = channel 0 code from edge k.
- Channel n captured at edge k+(n+1)W. sample_valid, sample_idx and sample_data are high/valid for the cycle following that edge.
- Edge k+4W: channel 3 sample, alarm commit and done all become visible together; select returns to 00000 at the same edge.
- Edge k+4W+1: IDLE, or ERROR with select=11111 and error_mode=1.
- With start held high, scans begin every 4W+2 cycles (14 with defaults).
- sample_valid pulses are never back-to-back when W>1; at W=1 they are continuous for 4 cycles.
- clear_error sampled at edge m -> select=00000 and error_mode=0 after edge m.

## Test plan
- Defaults; mux model gives clean=40, temp=25, food=20, salt=50; start at edge 0 -> select 00010/00100/01000/10000 for 3 cycles each; sample_valid after edges 3, 6, 9, 12 with data 40, 25, 20, 50 and idx 0..3; done after edge 12; alarm=0000.
- Boundary values: clean=32, temp=30, food=16, salt=64 -> alarm=0000. Then temp=31 -> alarm=0010; clean=31, temp=19 -> alarm=0011; salt=65 -> bit 3 set.
- Three consecutive scans with salt=65 -> error_mode=1 and select=11111 one cycle after the third done. start is then ignored. clear_error=1 -> select=00000, alarm=0000, error_mode=0.
- Fault counter reset: bad, bad, good, bad, bad scans -> error_mode stays 0 throughout.
- reset asserted during the channel 1 window (cycle 5) -> all outputs 0 with no clock edge. After release, start -> sampling restarts at channel 0; no stale done or sample_valid.
- start held high, SETTLE_CYCLES=0 -> scans every 6 cycles; sample_valid high 4 consecutive cycles per scan; start and clear_error together in ERROR -> IDLE, no scan begins.
